// File: rtl/ext_pipe.sv
// Pipelined immediate extender: combinational extension, registered output stage,
// one-entry skid buffer behind it, synchronous flush and a saturating illegal-opcode counter.
module ext_pipe #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHIFT_B = 2,
    parameter int ERR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext_out,
    output logic              ext_err,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [2:0] OP_SIGN = 3'b000;
    localparam logic [2:0] OP_ZERO = 3'b001;
    localparam logic [2:0] OP_LUI  = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [2:0] OP_SHL1 = 3'b100;

    // Returns {err, value}; illegal opcodes yield a zero value with err set.
    function automatic logic [DATA_W:0] extend(input logic [IMM_W-1:0] i, input logic [2:0] op);
        logic signed [DATA_W-1:0] s;
        logic        [DATA_W-1:0] r;
        logic                     e;
        s = {{(DATA_W-IMM_W){i[IMM_W-1]}}, i};
        r = '0;
        e = 1'b0;
        case (op)
            OP_SIGN: r = s;
            OP_ZERO: r = {{(DATA_W-IMM_W){1'b0}}, i};
            OP_LUI:  r = {i, {(DATA_W-IMM_W){1'b0}}};
            OP_BR:   r = s <<< SHIFT_B;
            OP_SHL1: r = s <<< 1;
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

    logic [DATA_W-1:0] ext_p0;
    logic              err_p0;
    logic [DATA_W-1:0] skid_ext_p1;
    logic              skid_err_p1;
    logic              vld_p1;
    logic              vld_p2;
    logic              accept;
    logic              main_free;

    // Stage p0: combinational extension of the presented immediate
    assign {err_p0, ext_p0} = extend(imm, eop);

    assign in_ready  = !vld_p1 && !reset;
    assign accept    = in_valid && in_ready;
    assign main_free = !vld_p2 || out_ready;
    assign out_valid = vld_p2;

    // Stage p1: skid entry, only written while the main register is held
    always_ff @(posedge clk) begin
        if (accept && !main_free) begin
            skid_ext_p1 <= ext_p0;
            skid_err_p1 <= err_p0;
        end
    end

    // Stage p2: main register driving the outputs, plus both valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            ext_out <= '0;
            ext_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (accept && err_p0) begin
                err_cnt <= sat_inc(err_cnt);
            end
            if (flush) begin
                vld_p1 <= 1'b0;
                vld_p2 <= 1'b0;
            end else if (main_free) begin
                if (vld_p1) begin
                    ext_out <= skid_ext_p1;
                    ext_err <= skid_err_p1;
                    vld_p2  <= 1'b1;
                    vld_p1  <= 1'b0;
                end else if (accept) begin
                    ext_out <= ext_p0;
                    ext_err <= err_p0;
                    vld_p2  <= 1'b1;
                end else begin
                    vld_p2  <= 1'b0;
                end
            end else if (accept) begin
                vld_p1 <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: mode table, back-pressure ordering, flush, counter saturation,
// reset mid-stream, and a 64-bit parameter instance.
module tb_ext_pipe;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [IW-1:0] imm;
    logic [2:0]    eop;
    logic          in_ready, out_valid, ext_err;
    logic [DW-1:0] ext_out;
    logic [EW-1:0] err_cnt;

    logic          in_valid64, in_ready64, out_valid64, ext_err64, out_ready64;
    logic [15:0]   imm64;
    logic [2:0]    eop64;
    logic [63:0]   ext_out64;
    logic [7:0]    err_cnt64;

    always #5 clk = ~clk;

    ext_pipe #(.DATA_W(DW), .IMM_W(IW), .SHIFT_B(2), .ERR_W(EW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .imm(imm), .eop(eop), .out_valid(out_valid), .out_ready(out_ready),
        .ext_out(ext_out), .ext_err(ext_err), .err_cnt(err_cnt)
    );

    ext_pipe #(.DATA_W(64), .IMM_W(16), .SHIFT_B(2), .ERR_W(8)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid64), .in_ready(in_ready64),
        .imm(imm64), .eop(eop64), .out_valid(out_valid64), .out_ready(out_ready64),
        .ext_out(ext_out64), .ext_err(ext_err64), .err_cnt(err_cnt64)
    );

    typedef struct packed {
        logic [DW-1:0] val;
        logic          err;
    } exp_t;

    typedef struct {
        logic [2:0]    eop;
        logic [IW-1:0] imm;
        logic [DW-1:0] val;
        logic          err;
    } vec_t;

    exp_t q[$];
    exp_t cur_exp;
    exp_t got;
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard: push expected on accept, pop and compare on consume
    always @(negedge clk) begin
        if (reset || flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %h/%b with nothing pending", ext_out, ext_err);
                end else begin
                    got = q.pop_front();
                    if (ext_out !== got.val || ext_err !== got.err) begin
                        errors++;
                        $display("FAIL sb_data: got %h/%b expected %h/%b", ext_out, ext_err, got.val, got.err);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(cur_exp);
        end
    end

    task automatic send(input logic [2:0] e, input logic [IW-1:0] i, input logic [DW-1:0] v, input logic er);
        int n;
        eop      = e;
        imm      = i;
        cur_exp  = '{val: v, err: er};
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready %b expected 1 within 20 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (er) exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
    endtask

    initial begin
        tbl[0] = '{3'b000, 16'h8001, 32'hFFFF8001, 1'b0};
        tbl[1] = '{3'b001, 16'h8001, 32'h00008001, 1'b0};
        tbl[2] = '{3'b010, 16'h8001, 32'h80010000, 1'b0};
        tbl[3] = '{3'b011, 16'h8001, 32'hFFFE0004, 1'b0};
        tbl[4] = '{3'b100, 16'h8001, 32'hFFFF0002, 1'b0};
        tbl[5] = '{3'b101, 16'h1234, 32'h00000000, 1'b1};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        imm = '0; eop = '0; cur_exp = '0;
        in_valid64 = 1'b0; imm64 = '0; eop64 = '0; out_ready64 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ext_out", ext_out, 0);
        chk("rst_ext_err", ext_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", in_ready, 1);

        for (int t = 0; t < 6; t++) begin
            send(tbl[t].eop, tbl[t].imm, tbl[t].val, tbl[t].err);
            chk($sformatf("latency_%0d", t), out_valid, 1);
            chk($sformatf("direct_out_%0d", t), ext_out, tbl[t].val);
        end
        chk("illegal_err_cnt", err_cnt, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_out_valid", out_valid, 0);
        chk("table_drained", q.size(), 0);

        // Back-pressure: two items buffered, third waits for the skid to drain
        out_ready = 1'b0;
        send(3'b001, 16'h0001, 32'h1, 1'b0);
        send(3'b001, 16'h0002, 32'h2, 1'b0);
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        eop = 3'b001; imm = 16'h0003; cur_exp = '{val: 32'h3, err: 1'b0}; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_held", in_ready, 0);
        chk("bp_out_stable", ext_out, 32'h1);
        out_ready = 1'b1;
        send(3'b001, 16'h0003, 32'h3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_drained", q.size(), 0);
        chk("bp_out_valid_end", out_valid, 0);

        // Flush with both entries full and input presented
        out_ready = 1'b0;
        send(3'b001, 16'h000A, 32'hA, 1'b0);
        send(3'b001, 16'h000B, 32'hB, 1'b0);
        eop = 3'b001; imm = 16'h000C; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_err_cnt", err_cnt, exp_cnt);
        // Flush while an illegal input is accepted: dropped but still counted
        send(3'b001, 16'h000D, 32'hD, 1'b0);
        eop = 3'b111; imm = 16'h000E; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_cnt = exp_cnt + 1;
        chk("flush2_out_valid", out_valid, 0);
        chk("flush2_err_cnt", err_cnt, exp_cnt);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_no_output", out_valid, 0);

        // Saturation of the illegal-opcode counter
        for (int k = 0; k < 300; k++) begin
            send(3'(5 + (k % 3)), 16'(k), 32'h0, 1'b1);
            if (k == 100) chk("sat_mid", err_cnt, exp_cnt);
        end
        chk("sat_final", err_cnt, 255);
        repeat (2) @(posedge clk);
        #1;
        chk("sat_drained", q.size(), 0);

        // Reset with data buffered
        out_ready = 1'b0;
        send(3'b001, 16'h0055, 32'h55, 1'b0);
        send(3'b001, 16'h0066, 32'h66, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_ext_out", ext_out, 0);
        chk("mrst_err_cnt", err_cnt, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mrst_in_ready_after", in_ready, 1);
        chk("mrst_out_valid_after", out_valid, 0);

        // 64-bit instance
        chk("w64_in_ready", in_ready64, 1);
        eop64 = 3'b011; imm64 = 16'hFFFF; in_valid64 = 1'b1;
        @(posedge clk); #1;
        chk("w64_br_valid", out_valid64, 1);
        chk("w64_br", ext_out64, 64'hFFFFFFFFFFFFFFFC);
        eop64 = 3'b010; imm64 = 16'h0001;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        chk("w64_lui", ext_out64, 64'h0001000000000000);
        chk("w64_err", {ext_err64, err_cnt64}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined immediate extender for the pipelined datapath. It accepts an immediate field and an extension opcode through a valid/ready handshake, computes the extended operand (sign, zero, upper-load, branch-offset or halfword-shift), and presents it from a registered output stage. A two-entry skid buffer decouples downstream stalls from the decode stage. A synchronous flush supports branch squashes, and a saturating counter records illegal opcodes.

## Interface
- DATA_W, 32, output operand width; must be greater than IMM_W.
- IMM_W, 16, immediate field width.
- SHIFT_B, 2, left shift applied in BR mode; must be less than DATA_W − IMM_W.
- ERR_W, 8, width of the illegal-opcode counter.

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all buffered results.
- in_valid  in  1  upstream has imm/eop valid.
- in_ready  out  1  block can accept this cycle.
- imm  in  IMM_W  immediate field.
- eop  in  3  extension opcode.
- out_valid  out  1  ext_out/ext_err valid.
- out_ready  in  1  downstream accepts this cycle.
- ext_out  out  DATA_W  extended operand.
- ext_err  out  1  result came from an illegal eop.
- err_cnt  out  ERR_W  saturating count of accepted illegal eops.

## Operation
- Opcodes, with S = sign-extension of imm to DATA_W:
  - 000 SIGN: S.
  - 001 ZERO: imm zero-extended.
  - 010 LUI: imm in bits [DATA_W-1 : DATA_W-IMM_W], zeros below.
  - 011 BR: S << SHIFT_B, truncated to DATA_W.
  - 100 SHL1: S << 1, truncated to DATA_W.
  - 101–111 illegal: ext_out = 0, ext_err = 1.
- Extension is combinational from imm/eop and is registered on acceptance. Only the extended result and err flag are stored; imm is not kept.
- Storage consists of a main register (drives the outputs) and a skid register. Each has a valid bit.
- Accept condition: in_valid && in_ready.
- in_ready = !skid_valid && !reset (combinational from registered state; not dependent on out_ready).
- Consume condition: out_valid && out_ready.
- Per-cycle update, in priority order:
  1. reset: both valid bits = 0, ext_out = 0, ext_err = 0, err_cnt = 0.
  2. flush: both valid bits = 0. Any input accepted this cycle is discarded. err_cnt still counts an illegal eop accepted this cycle.
  3. Otherwise, the main register loads:
     - the skid contents, if main is empty or consumed and skid is valid (skid valid clears);
     - the new input, if main is empty or consumed, skid is empty, and an input is accepted.
  4. Otherwise, if main is held and an input is accepted, the input goes to skid.
- Ordering is strictly FIFO. Simultaneous consume and accept with skid valid: skid→main, and the input is not accepted (in_ready was 0).
- err_cnt increments by 1 on each accepted illegal eop and saturates at 2^ERR_W − 1; it does not wrap. Only reset clears it; flush does not.

## Timing
- Latency: 1 cycle; input accepted at edge N appears on ext_out after edge N.
- Throughput: 1 result per cycle while out_ready = 1.
- Stall: out_ready low for k cycles absorbs one extra item. in_ready falls the cycle after the skid fills and rises the cycle after skid drains.
- Outputs hold stable while out_valid && !out_ready.
- ext_out/ext_err are undefined-but-stable when out_valid = 0; the implementation keeps their last value.
- Reset values: out_valid 0, in_ready 0 during reset (1 the cycle after), ext_out 0, ext_err 0, err_cnt 0.
- Reset or flush mid-stall drops both entries; out_valid is 0 the next cycle.

## Test plan
- Mode sweep, out_ready = 1, imm = 0x8001:
  - SIGN → 0xFFFF8001
  - ZERO → 0x00008001
  - LUI → 0x80010000
  - BR → 0xFFFE0004
  - SHL1 → 0xFFFF0002
  - each 1 cycle after acceptance.
- Illegal: eop = 101, imm = 0x1234 → ext_out 0, ext_err 1, err_cnt 1. Send 300 illegal ops with ERR_W = 8 → err_cnt saturates at 255.
- Back-pressure: stream 0x0001, 0x0002, 0x0003 (ZERO) with out_ready = 0 from cycle 1:
  - first two are buffered;
  - in_ready = 0 after the skid fills;
  - releasing out_ready yields 0x1, 0x2, 0x3 in order with no loss or duplicate.
- Flush with both entries full and in_valid high → out_valid 0 the next cycle; the flushed input never appears; err_cnt unchanged for legal ops.
- Reset mid-stream with data buffered → all outputs at reset values the next cycle; in_ready = 1 the cycle after reset deasserts.
- Parameter check, DATA_W = 64, IMM_W = 16, SHIFT_B = 2: BR of 0xFFFF → 0xFFFFFFFFFFFFFFFC; LUI of 0x0001 → 0x0001000000000000.
